// File: rtl/my_slave_access_arbiter.sv
// Round-robin arbiter sharing one my_slave en/rdy port between N requesters.
// One outstanding transaction, bounded rdy wait, return-to-zero recovery.
module my_slave_access_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                slv_en,
  output logic [DW-1:0]       slv_data,
  input  logic                slv_rdy,
  output logic                timeout_err,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RECOVER
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nx;
  logic [PW-1:0]    r_win;
  logic [PW-1:0]    w_win_nx;
  logic [PW-1:0]    w_pick;
  logic             w_hit;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nx;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] w_done_nx;
  logic             r_en;
  logic             w_en_nx;
  logic             r_terr;
  logic             w_terr_nx;
  logic             r_busy;
  logic [DW-1:0]    r_data;
  logic [DW-1:0]    w_data_nx;
  logic [DW-1:0]    w_req_word;
  logic [N_REQ-1:0] w_onehot;

  function automatic logic [PW-1:0] f_wrap(
    input logic [PW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  // first requester at or after r_ptr, wrapping
  always_comb begin
    w_hit  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_hit && req[f_wrap(r_ptr, k)]) begin
        w_hit  = 1'b1;
        w_pick = f_wrap(r_ptr, k);
      end
    end
  end

  assign w_req_word = req_data[int'(w_pick)*DW +: DW];
  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_cnt_nx   = r_cnt;
    w_gnt_nx   = r_gnt;
    w_done_nx  = '0;
    w_terr_nx  = 1'b0;
    w_en_nx    = r_en;
    w_data_nx  = r_data;
    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_win_nx   = w_pick;
          w_gnt_nx   = w_onehot;
          w_data_nx  = w_req_word;
          w_en_nx    = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (slv_rdy || r_cnt == CW'(TIMEOUT-1)) begin
          w_en_nx    = 1'b0;
          w_gnt_nx   = '0;
          w_done_nx  = r_gnt;
          w_terr_nx  = !slv_rdy;
          w_ptr_nx   = f_wrap(r_win, 1);
          w_state_nx = RECOVER;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      RECOVER: begin
        if (!slv_rdy) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_en    <= 1'b0;
      r_terr  <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
      r_cnt   <= w_cnt_nx;
      r_gnt   <= w_gnt_nx;
      r_done  <= w_done_nx;
      r_en    <= w_en_nx;
      r_terr  <= w_terr_nx;
      r_data  <= w_data_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign slv_en      = r_en;
  assign slv_data    = r_data;
  assign timeout_err = r_terr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_my_slave_access_arbiter.sv
// Bench for my_slave_access_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_my_slave_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            slv_en;
  logic [DW-1:0]   slv_data;
  logic            slv_rdy = 1'b0;
  logic            timeout_err;
  logic            busy;

  my_slave_access_arbiter #(
    .N_REQ(N), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .slv_en(slv_en), .slv_data(slv_data),
    .slv_rdy(slv_rdy), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // slave: 0 = answer after lat en cycles, hold rdy hold cycles; 1 = mute;
  // 2 = random rdy
  int sl_mode = 0;
  int lat = 1;
  int hold = 0;
  int ecnt = 0;
  int hcnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      slv_rdy = 1'b0;
      ecnt = 0;
      hcnt = 0;
    end else begin
      case (sl_mode)
        0: begin
          if (slv_en) begin
            hcnt = 0;
            if (!slv_rdy) begin
              ecnt++;
              if (ecnt >= lat) slv_rdy = 1'b1;
            end
          end else begin
            ecnt = 0;
            if (slv_rdy) begin
              hcnt++;
              if (hcnt > hold) slv_rdy = 1'b0;
            end
          end
        end
        1: slv_rdy = 1'b0;
        default: slv_rdy = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // reference model: phase 0 idle, 1 talking to slave, 2 waiting rdy low
  int           m_phase;
  int           m_ptr;
  int           m_win;
  int           m_waited;
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_done;
  logic         m_en;
  logic         m_terr;
  logic [DW-1:0] m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_waited = 0;
      m_gnt = '0; m_done = '0; m_en = 1'b0; m_terr = 1'b0; m_data = '0;
    end else begin
      case (m_phase)
        0: begin
          m_done = '0;
          m_terr = 1'b0;
          if (req != 0) begin
            int bd;
            bd = N;
            for (int i = 0; i < N; i++)
              if (req[i] && ((i - m_ptr + N) % N) < bd) begin
                bd = (i - m_ptr + N) % N;
                m_win = i;
              end
            m_gnt = '0;
            m_gnt[m_win] = 1'b1;
            m_data = req_data[m_win*DW +: DW];
            m_en = 1'b1;
            m_waited = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_waited++;
          if (slv_rdy || m_waited == TO) begin
            m_terr = !slv_rdy;
            m_en = 1'b0;
            m_gnt = '0;
            m_done = '0;
            m_done[m_win] = 1'b1;
            m_ptr = (m_win + 1) % N;
            m_phase = 2;
          end
        end
        default: begin
          m_done = '0;
          m_terr = 1'b0;
          if (!slv_rdy) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("done", 64'(done), 64'(m_done));
    chk("slv_en", 64'(slv_en), 64'(m_en));
    chk("slv_data", 64'(slv_data), 64'(m_data));
    chk("timeout_err", 64'(timeout_err), 64'(m_terr));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("inv_gnt_onehot", 64'($onehot0(gnt)), 64'(1));
    chk("inv_done_onehot", 64'($onehot0(done)), 64'(1));
    chk("inv_terr_done", 64'(!timeout_err || (done != 0)), 64'(1));
  end

  bit auto_drop = 1'b1;

  task automatic tick();
    @(negedge clk);
    #1;
    if (auto_drop) req = req & ~done;
  endtask

  function automatic bit cond(input int w);
    case (w)
      0: return slv_en;
      1: return done != 0;
      2: return gnt != 0;
      3: return gnt == 0;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input int lim, input string nm);
    int n;
    n = 0;
    while (!cond(w) && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 64'(cond(w)), 64'(1));
  endtask

  int n;
  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_en", 64'(slv_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_data", 64'(slv_data), 64'(0));
    rst = 1'b1;
    tick();

    // single request
    req_data[1*DW +: DW] = 32'hA5A5_0001;
    lat = 3;
    req = 4'b0010;
    tick();
    chk("t1_en", 64'(slv_en), 64'(1));
    chk("t1_data", 64'(slv_data), 64'h0000_0000_A5A5_0001);
    chk("t1_gnt", 64'(gnt), 64'(4'b0010));
    wait_for(1, 40, "t1_wait_done");
    chk("t1_done", 64'(done), 64'(4'b0010));
    chk("t1_terr", 64'(timeout_err), 64'(0));
    wait_for(4, 40, "t1_wait_idle");

    // timeout
    sl_mode = 1;
    req = 4'b1000;
    wait_for(0, 10, "to_wait_en");
    n = 0;
    while (slv_en && n < 40) begin
      tick();
      n++;
    end
    chk("to_len", 64'(n), 64'(16));
    chk("to_done", 64'(done), 64'(4'b1000));
    chk("to_terr", 64'(timeout_err), 64'(1));

    // continuous round robin, starting after the timed-out requester 3
    sl_mode = 0;
    lat = 1;
    hold = 0;
    auto_drop = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_for(2, 40, "rr_wait_gnt");
      chk("rr_gnt", 64'(gnt), 64'(1) << order[g]);
      wait_for(3, 40, "rr_wait_end");
    end

    // sticky rdy
    hold = 5;
    wait_for(1, 40, "st_wait_done");
    n = 0;
    while (slv_rdy && n < 20) begin
      chk("st_busy", 64'(busy), 64'(1));
      chk("st_en_low", 64'(slv_en), 64'(0));
      tick();
      n++;
    end
    n = 0;
    while (!slv_en && n < 10) begin
      tick();
      n++;
    end
    chk("st_gap", 64'(n), 64'(2));
    hold = 0;
    req = 4'b0000;
    wait_for(4, 60, "st_wait_idle");

    // async reset mid-wait
    sl_mode = 1;
    req = 4'b0100;
    wait_for(0, 10, "ar_wait_en");
    tick();
    tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_en", 64'(slv_en), 64'(0));
    chk("ar_gnt", 64'(gnt), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_done", 64'(done), 64'(0));
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    sl_mode = 0;
    lat = 2;
    req = 4'b1111;
    wait_for(2, 10, "ar_wait_gnt");
    chk("ar_first", 64'(gnt), 64'(4'b0001));
    req = 4'b0000;
    wait_for(4, 60, "ar_wait_idle");

    // requester drops mid-transaction
    lat = 3;
    req = 4'b0001;
    wait_for(0, 10, "dr_wait_en");
    req = 4'b0000;
    wait_for(1, 40, "dr_wait_done");
    chk("dr_done", 64'(done), 64'(4'b0001));
    wait_for(4, 60, "dr_wait_idle");

    // random traffic
    auto_drop = 1'b1;
    sl_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

endmodule
